// File: rtl/mbisr_mem_responder.sv
// rtl/mbisr_mem_responder.sv - memory-under-test with stuck-at-0 injection and spare-word repair map
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready drops while a repair is presented)
//   req_we/req_addr/req_wdata  request: write flag, address, write data
//   rsp_valid/rsp_rdata        read response, registered one cycle after acceptance
//   repair_en/repair_addr      repair command pulse and address to remap
//   repair_ack                 one-cycle completion pulse per repair command
//   repair_full                sticky: a repair found no free spare
//   spares_used                number of allocated spare entries
//   fault_en/fault_addr/fault_bit  stuck-at-0 injection on main-array reads
module mbisr_mem_responder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int SPARES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              repair_en,
    input  logic [ADDR_W-1:0] repair_addr,
    output logic              repair_ack,
    output logic              repair_full,
    output logic [2:0]        spares_used,
    input  logic              fault_en,
    input  logic [ADDR_W-1:0] fault_addr,
    input  logic [2:0]        fault_bit
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, ACK} state_t;
    state_t state, state_next;

    logic [DATA_W-1:0] main_mem  [DEPTH];
    logic [DATA_W-1:0] spare_mem [SPARES];
    logic [ADDR_W-1:0] map_addr  [SPARES];
    logic [SPARES-1:0] map_valid;

    // One-hot match vectors; a repair never allocates an already-mapped
    // address, so at most one bit is ever set.
    logic [SPARES-1:0] req_sel;
    logic [SPARES-1:0] rep_sel;
    logic              req_hit;
    logic              rep_hit;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] fault_mask;
    logic              req_fire;

    assign req_ready  = !repair_en;
    assign req_fire   = req_valid && req_ready;
    assign fault_mask = ~({{(DATA_W-1){1'b0}}, 1'b1} << fault_bit);

    always_comb begin
        req_sel = '0;
        rep_sel = '0;
        for (int i = 0; i < SPARES; i++) begin
            req_sel[i] = map_valid[i] && (map_addr[i] == req_addr);
            rep_sel[i] = map_valid[i] && (map_addr[i] == repair_addr);
        end
    end

    assign req_hit = |req_sel;
    assign rep_hit = |rep_sel;

    // Fault only corrupts the returned main-array word, never storage or spares.
    always_comb begin
        rd_data = main_mem[req_addr];
        if (fault_en && (req_addr == fault_addr))
            rd_data = rd_data & fault_mask;
        for (int i = 0; i < SPARES; i++) begin
            if (req_sel[i])
                rd_data = spare_mem[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A new repair in ACK re-enters ACK, so each command gets its own ack cycle.
    always_comb begin
        state_next = state;
        repair_ack = 1'b0;
        case (state)
            IDLE: if (repair_en) state_next = ACK;
            ACK: begin
                repair_ack = 1'b1;
                state_next = repair_en ? ACK : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) main_mem[i] <= '0;
            for (int i = 0; i < SPARES; i++) begin
                spare_mem[i] <= '0;
                map_addr[i]  <= '0;
            end
            map_valid   <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            repair_full <= 1'b0;
            spares_used <= 3'd0;
        end else begin
            rsp_valid <= 1'b0;
            if (req_fire) begin
                if (req_we) begin
                    if (req_hit) begin
                        for (int i = 0; i < SPARES; i++)
                            if (req_sel[i]) spare_mem[i] <= req_wdata;
                    end else begin
                        main_mem[req_addr] <= req_wdata;
                    end
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rd_data;
                end
            end
            // Request and repair never fire together (req_ready), so the
            // spare clear below cannot collide with a spare write above.
            if (repair_en && !rep_hit) begin
                if (spares_used < 3'(SPARES)) begin
                    for (int i = 0; i < SPARES; i++) begin
                        if (3'(i) == spares_used) begin
                            map_addr[i]  <= repair_addr;
                            map_valid[i] <= 1'b1;
                            spare_mem[i] <= '0;
                        end
                    end
                    spares_used <= spares_used + 3'd1;
                end else begin
                    repair_full <= 1'b1;
                end
            end
        end
    end
endmodule
